iter_divider: RTL and testbench



---
 rtl/div_pkg.sv | 44 ++++
 rtl/iter_divider.sv | 161 ++++++++++++++++
 tb/tb_iter_divider.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// ============================================================================
// Module      : div_pkg
// Description : Shared definitions for the iterative divider: operand width,
//               FSM state type, divide-by-zero quotient constant and the
//               sign-handling helpers used around the unsigned-magnitude core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

    localparam int DIV_WIDTH = 32;

    // Quotient returned when the divisor is zero (all ones).
    localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // Two's-complement negation when en is set, pass-through otherwise.
    function automatic logic [DIV_WIDTH-1:0] negateIf(
        input logic [DIV_WIDTH-1:0] value,
        input logic                 en
    );
        return en ? (DIV_WIDTH'(0) - value) : value;
    endfunction

    // Magnitude of a value; only negative numbers in signed mode are flipped.
    // The most negative value maps onto itself, which reads correctly as an
    // unsigned magnitude.
    function automatic logic [DIV_WIDTH-1:0] absVal(
        input logic [DIV_WIDTH-1:0] value,
        input logic                 isSigned
    );
        return negateIf(value, isSigned & value[DIV_WIDTH-1]);
    endfunction

endpackage

`default_nettype wire

// File: rtl/iter_divider.sv
// ============================================================================
// Module      : iter_divider
// Description : Multi-cycle radix-2 restoring divider for DIV/DIVU. Signed
//               operands are reduced to magnitudes, divided in WIDTH steps,
//               then sign-corrected. Freezes EX through stall while busy and
//               pulses done with the {HI, LO} result.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               start, is_signed    - request and DIV/DIVU select (IDLE only)
//               dividend, divisor   - operands, sampled with start
//               cancel              - pipeline flush, aborts any operation
//               stall               - combinational freeze request
//               done                - one-cycle result-valid pulse
//               quotient, remainder - registered LO / HI values
//               hilo                - {remainder, quotient}
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iter_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    input  logic               cancel,
    output logic               stall,
    output logic               done,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic [2*WIDTH-1:0] hilo
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_lastCount = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_countOne  = CNT_W'(1);

    div_state_t       r_state;
    div_state_t       w_nextState;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_divisor;    // divisor magnitude
    logic [WIDTH-1:0] r_quoShift;   // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] r_partRem;    // committed partial remainder (always < divisor)
    logic             r_negQuo;
    logic             r_negRem;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;

    logic             w_accept;
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_trial;
    logic             w_borrow;

    assign w_accept = start & ~cancel;

    // One restoring step: the extra top bit of the trial difference is the borrow.
    assign w_shifted = {r_partRem, r_quoShift[WIDTH-1]};
    assign w_trial   = w_shifted - {1'b0, r_divisor};
    assign w_borrow  = w_trial[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        stall       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    stall       = 1'b1;
                    w_nextState = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                // Stall stays high in a cancel cycle; it drops once back in IDLE.
                stall = 1'b1;
                if (cancel) begin
                    w_nextState = IDLE;
                end else if (r_count == c_lastCount) begin
                    w_nextState = SIGN;
                end
            end
            SIGN: begin
                stall       = 1'b1;
                w_nextState = cancel ? IDLE : DONE;
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // A flush arriving in the DONE cycle suppresses the pulse.
    assign done = (r_state == DONE) & ~cancel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_divisor   <= '0;
            r_quoShift  <= '0;
            r_partRem   <= '0;
            r_negQuo    <= 1'b0;
            r_negRem    <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_divisor  <= absVal(divisor, is_signed);
                        r_quoShift <= absVal(dividend, is_signed);
                        r_partRem  <= '0;
                        r_count    <= '0;
                        r_negQuo   <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        r_negRem   <= is_signed & dividend[WIDTH-1];
                        // Divide-by-zero skips the core; raw dividend, no sign fix.
                        if (divisor == '0) begin
                            r_quotient  <= DIV0_QUOTIENT;
                            r_remainder <= dividend;
                        end
                    end
                end
                CALC: begin
                    if (!cancel) begin
                        r_quoShift <= {r_quoShift[WIDTH-2:0], ~w_borrow};
                        r_partRem  <= w_borrow ? w_shifted[WIDTH-1:0] : w_trial[WIDTH-1:0];
                        // Wraps to zero on the final step as the FSM leaves CALC.
                        r_count    <= r_count + c_countOne;
                    end
                end
                SIGN: begin
                    if (!cancel) begin
                        r_quotient  <= negateIf(r_quoShift, r_negQuo);
                        r_remainder <= negateIf(r_partRem, r_negRem);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign hilo      = {r_remainder, r_quotient};

endmodule

`default_nettype wire

// File: tb/tb_iter_divider.sv
// ============================================================================
// Module      : tb_iter_divider
// Description : Self-checking bench for iter_divider. A cycle-level reference
//               model (plain arithmetic plus a scheduled done cycle) is
//               compared against stall/done/quotient/remainder/hilo on every
//               cycle; directed tests add hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iter_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         isSigned;
    logic         cancel;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         stall;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic [2*W-1:0] hilo;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;
    int doneCount = 0;
    int lastDoneCyc = -1;

    iter_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (isSigned),
        .dividend  (dividend),
        .divisor   (divisor),
        .cancel    (cancel),
        .stall     (stall),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .hilo      (hilo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Architectural DIV/DIVU result.
    task automatic refDivide(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                             output logic [W-1:0] q, output logic [W-1:0] r);
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = a;
                r = '0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // Reference model state: pending result, cycle it must appear, held outputs.
    int           doneAt = -1;
    logic [W-1:0] pendQ = '0, pendR = '0, holdQ = '0, holdR = '0;
    bit           armed = 1'b0;

    always @(negedge clk) begin : compare
        bit active, expStall, expDone;
        active = (doneAt >= 0) && (cyc <= doneAt);
        if (done) begin
            doneCount++;
            lastDoneCyc = cyc;
        end
        if (armed) begin
            expStall = (!active && start && !cancel) || (active && cyc < doneAt);
            expDone  = active && (cyc == doneAt) && !cancel;
            check("stall", 64'(stall), 64'(expStall));
            check("done", 64'(done), 64'(expDone));
            check("quotient", 64'(quotient), 64'(holdQ));
            check("remainder", 64'(remainder), 64'(holdR));
            check("hilo", hilo, {holdR, holdQ});
        end
        if (rst) begin
            doneAt = -1;
            holdQ  = '0;
            holdR  = '0;
            armed  = 1'b1;
        end else begin
            if (active && cancel) begin
                doneAt = -1;
            end else begin
                if (active && cyc == doneAt - 1) begin
                    holdQ = pendQ;
                    holdR = pendR;
                end
                if (active && cyc == doneAt) doneAt = -1;
            end
            if (!active && start && !cancel) begin
                refDivide(isSigned, dividend, divisor, pendQ, pendR);
                doneAt = cyc + ((divisor == '0) ? 1 : W + 2);
                if (divisor == '0) begin
                    holdQ = pendQ;
                    holdR = pendR;
                end
            end
        end
    end

    task automatic toCycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic runOp(input string name, input logic sgn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] expQ,
                         input logic [W-1:0] expR, input int expLat);
        int t0, lat;
        @(posedge clk);
        #1;
        t0       = cyc;
        start    = 1'b1;
        isSigned = sgn;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = -1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done) begin
                lat = cyc - t0;
                break;
            end
        end
        check({name, " latency"}, 64'(lat), 64'(expLat));
        check({name, " quotient"}, 64'(quotient), 64'(expQ));
        check({name, " remainder"}, 64'(remainder), 64'(expR));
    endtask

    int t0, dc0;

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        isSigned = 1'b0;
        cancel   = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset quotient", 64'(quotient), 64'd0);
        check("reset remainder", 64'(remainder), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset stall", 64'(stall), 64'd0);

        runOp("udiv 100/7",        1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          34);
        runOp("sdiv -7/2",         1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  34);
        runOp("sdiv 7/-2",         1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          34);
        runOp("sdiv overflow",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          34);
        runOp("udiv max/1",        1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          34);
        runOp("udiv by zero",      1'b0, 32'h1234,       32'd0,          32'hFFFF_FFFF,  32'h1234,       1);
        runOp("sdiv by zero",      1'b1, 32'h1234,       32'd0,          32'hFFFF_FFFF,  32'h1234,       1);
        runOp("udiv deadbeef",     1'b0, 32'hDEAD_BEEF,  32'h1000,       32'h000D_EADB,  32'h0000_0EEF,  34);
        runOp("sdiv -100/7",       1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  34);

        // Cancel mid-CALC, then a fresh request right after.
        @(posedge clk);
        #1;
        t0       = cyc;
        dc0      = doneCount;
        start    = 1'b1;
        isSigned = 1'b0;
        dividend = 32'd100;
        divisor  = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        toCycle(t0 + 10);
        cancel = 1'b1;
        toCycle(t0 + 11);
        cancel   = 1'b0;
        start    = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd3;
        @(negedge clk);
        check("cancel hold quotient", 64'(quotient), 64'(32'hFFFF_FFF2));
        check("cancel no done", 64'(doneCount - dc0), 64'd0);
        toCycle(t0 + 12);
        start = 1'b0;
        toCycle(t0 + 50);
        check("cancel done count", 64'(doneCount - dc0), 64'd1);
        check("restart done cycle", 64'(lastDoneCyc - t0), 64'd45);
        check("restart quotient", 64'(quotient), 64'd3);
        check("restart remainder", 64'(remainder), 64'd0);

        // Reset in the middle of an operation.
        @(posedge clk);
        #1;
        t0       = cyc;
        dc0      = doneCount;
        start    = 1'b1;
        dividend = 32'd100;
        divisor  = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        toCycle(t0 + 20);
        rst = 1'b1;
        toCycle(t0 + 21);
        rst = 1'b0;
        @(negedge clk);
        check("rst quotient", 64'(quotient), 64'd0);
        check("rst remainder", 64'(remainder), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst stall", 64'(stall), 64'd0);
        toCycle(t0 + 50);
        check("rst no done", 64'(doneCount - dc0), 64'd0);

        // start held during a busy operation must be ignored.
        @(posedge clk);
        #1;
        t0       = cyc;
        dc0      = doneCount;
        start    = 1'b1;
        dividend = 32'd100;
        divisor  = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        toCycle(t0 + 5);
        start    = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd5;
        toCycle(t0 + 31);
        start = 1'b0;
        toCycle(t0 + 60);
        check("busy start done count", 64'(doneCount - dc0), 64'd1);
        check("busy start done cycle", 64'(lastDoneCyc - t0), 64'd34);
        check("busy start quotient", 64'(quotient), 64'd14);
        check("busy start remainder", 64'(remainder), 64'd2);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
